// File: rtl/ram_pkg.sv
// Shared definitions for the frame-buffer writer and the display-side reader:
// default geometry, derived address space and the writer FSM state type.
package ram_pkg;

    localparam int RAM_WIDTH_DEF   = 32;
    localparam int PIXEL_WIDTH_DEF = 24;
    localparam int N_BITS_DEF      = 480 * 360 * 24;
    localparam int RAM_DEPTH_DEF   = N_BITS_DEF / RAM_WIDTH_DEF;
    localparam int MAX_ADRESS_DEF  = RAM_DEPTH_DEF - 1;
    localparam int ADRESS_BITS_DEF = $clog2(RAM_DEPTH_DEF);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    function automatic int ram_depth(input int n_bits, input int ram_width);
        return n_bits / ram_width;
    endfunction

endpackage

// File: rtl/ram_frame_writer_pixel_packer.sv
// LSB-first packer: appends PIXEL_WIDTH-bit pixels to a bit buffer and reports
// a full RAM_WIDTH-bit word on the append that completes it.
module pixel_packer
    import ram_pkg::*;
#(
    parameter int RAM_WIDTH   = RAM_WIDTH_DEF,
    parameter int PIXEL_WIDTH = PIXEL_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_clear,
    input  logic                   i_append,
    input  logic [PIXEL_WIDTH-1:0] i_pixel,
    output logic                   o_word_done,
    output logic [RAM_WIDTH-1:0]   o_word
);

    localparam int BUF_W  = RAM_WIDTH + PIXEL_WIDTH;
    localparam int FILL_W = $clog2(BUF_W) + 1;
    localparam logic [FILL_W-1:0] PIX_W_F = FILL_W'(PIXEL_WIDTH);
    localparam logic [FILL_W-1:0] RAM_W_F = FILL_W'(RAM_WIDTH);

    logic [BUF_W-1:0]  r_buf;
    logic [BUF_W-1:0]  w_base_buf;
    logic [BUF_W-1:0]  w_placed;
    logic [BUF_W-1:0]  w_buf_nxt;
    logic [FILL_W-1:0] r_fill;
    logic [FILL_W-1:0] w_base_fill;
    logic [FILL_W-1:0] w_sum;
    logic [FILL_W-1:0] w_fill_nxt;

    // Clear takes effect before the append so a frame-start pixel lands at bit 0
    always_comb begin
        if (i_clear) begin
            w_base_buf  = '0;
            w_base_fill = '0;
        end else begin
            w_base_buf  = r_buf;
            w_base_fill = r_fill;
        end
        w_placed    = w_base_buf | ({{RAM_WIDTH{1'b0}}, i_pixel} << w_base_fill);
        w_sum       = w_base_fill + PIX_W_F;
        o_word      = w_placed[RAM_WIDTH-1:0];
        o_word_done = 1'b0;
        w_buf_nxt   = w_base_buf;
        w_fill_nxt  = w_base_fill;
        if (i_append) begin
            if (w_sum >= RAM_W_F) begin
                o_word_done = 1'b1;
                w_buf_nxt   = w_placed >> RAM_WIDTH;
                w_fill_nxt  = w_sum - RAM_W_F;
            end else begin
                o_word_done = 1'b0;
                w_buf_nxt   = w_placed;
                w_fill_nxt  = w_sum;
            end
        end else begin
            o_word_done = 1'b0;
            w_buf_nxt   = w_base_buf;
            w_fill_nxt  = w_base_fill;
        end
    end

    // Buffer and fill-count state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_buf  <= '0;
            r_fill <= '0;
        end else begin
            r_buf  <= w_buf_nxt;
            r_fill <= w_fill_nxt;
        end
    end

endmodule

// File: rtl/ram_frame_writer.sv
// Frame-buffer writer: packs the pixel stream into RAM words and writes them
// sequentially from address 0 to the last word of the frame.
module ram_frame_writer
    import ram_pkg::*;
#(
    parameter int RAM_WIDTH   = RAM_WIDTH_DEF,
    parameter int PIXEL_WIDTH = PIXEL_WIDTH_DEF,
    parameter int N_BITS      = N_BITS_DEF,
    localparam int RAM_DEPTH   = ram_depth(N_BITS, RAM_WIDTH),
    localparam int MAX_ADRESS  = RAM_DEPTH - 1,
    localparam int ADRESS_BITS = $clog2(RAM_DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PIXEL_WIDTH-1:0] pixel,
    input  logic                   pixel_valid,
    input  logic                   sof,
    output logic                   pixel_ready,
    input  logic                   ram_ready,
    output logic                   we,
    output logic [ADRESS_BITS-1:0] adress,
    output logic [RAM_WIDTH-1:0]   data_out,
    output logic                   frame_done,
    output logic                   frame_err
);

    localparam logic [ADRESS_BITS-1:0] MAX_ADR = ADRESS_BITS'(MAX_ADRESS);
    localparam logic [ADRESS_BITS-1:0] ADR_ONE = ADRESS_BITS'(1);

    state_t                 r_state;
    logic                   r_we;
    logic [ADRESS_BITS-1:0] r_adress;
    logic [RAM_WIDTH-1:0]   r_data_out;
    logic                   r_frame_done;
    logic                   r_frame_err;

    logic                   w_accept;
    logic                   w_retire;
    logic                   w_last_retire;
    logic                   w_sof_acc;
    logic                   w_append;
    logic                   w_clear;
    logic                   w_word_done;
    logic [RAM_WIDTH-1:0]   w_word;

    // Handshake decode; a pixel arriving as the last word retires belongs to the next frame
    always_comb begin
        pixel_ready   = (r_state == ST_IDLE) || !r_we || ram_ready;
        w_accept      = pixel_valid && pixel_ready;
        w_retire      = r_we && ram_ready;
        w_last_retire = w_retire && (r_adress == MAX_ADR);
        w_sof_acc     = w_accept && sof;
        w_append      = w_sof_acc || (w_accept && (r_state == ST_ACTIVE) && !w_last_retire);
        w_clear       = w_sof_acc || w_last_retire;
    end

    pixel_packer #(
        .RAM_WIDTH   (RAM_WIDTH),
        .PIXEL_WIDTH (PIXEL_WIDTH)
    ) u_packer (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_clear),
        .i_append    (w_append),
        .i_pixel     (pixel),
        .o_word_done (w_word_done),
        .o_word      (w_word)
    );

    // FSM, address counter and write-port registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_we         <= 1'b0;
            r_adress     <= '0;
            r_data_out   <= '0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_frame_done <= w_last_retire;
            r_frame_err  <= w_sof_acc && (r_state == ST_ACTIVE) && !w_last_retire;
            if (w_word_done) begin
                r_data_out <= w_word;
            end else begin
                r_data_out <= r_data_out;
            end
            if (w_sof_acc) begin
                r_state  <= ST_ACTIVE;
                r_adress <= '0;
                r_we     <= w_word_done;
            end else if (w_last_retire) begin
                r_state  <= ST_IDLE;
                r_adress <= '0;
                r_we     <= 1'b0;
            end else begin
                r_state  <= r_state;
                r_adress <= w_retire ? (r_adress + ADR_ONE) : r_adress;
                r_we     <= w_word_done || (r_we && !ram_ready);
            end
        end
    end

    assign we         = r_we;
    assign adress     = r_adress;
    assign data_out   = r_data_out;
    assign frame_done = r_frame_done;
    assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_ram_frame_writer.sv
// Scoreboard bench for ram_frame_writer on a reduced 96-word frame: a bit-queue
// packing model predicts every RAM write, frame_done and frame_err pulse.
module tb_ram_frame_writer;
    import ram_pkg::*;

    localparam int RW    = 32;
    localparam int PW    = 24;
    localparam int NB    = 3072;
    localparam int DEPTH = NB / RW;
    localparam int MAXA  = DEPTH - 1;
    localparam int AB    = $clog2(DEPTH);
    localparam int PIX_PER_FRAME = NB / PW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [PW-1:0] pixel = '0;
    logic          pixel_valid = 1'b0;
    logic          sof = 1'b0;
    logic          ram_ready = 1'b1;
    logic          pixel_ready;
    logic          we;
    logic [AB-1:0] adress;
    logic [RW-1:0] data_out;
    logic          frame_done;
    logic          frame_err;

    typedef struct {
        int            adr;
        logic [RW-1:0] data;
    } wr_t;

    wr_t sb_q[$];
    bit  bit_q[$];
    int  tests_run = 0;
    int  tests_failed = 0;
    int  m_adr = 0;
    bit  m_active = 1'b0;
    bit  err_exp = 1'b0;
    bit  done_exp = 1'b0;
    bit  throttle = 1'b0;
    int  write_cnt = 0;
    int  done_cnt = 0;
    int  err_cnt = 0;

    ram_frame_writer #(
        .RAM_WIDTH   (RW),
        .PIXEL_WIDTH (PW),
        .N_BITS      (NB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pixel       (pixel),
        .pixel_valid (pixel_valid),
        .sof         (sof),
        .pixel_ready (pixel_ready),
        .ram_ready   (ram_ready),
        .we          (we),
        .adress      (adress),
        .data_out    (data_out),
        .frame_done  (frame_done),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference packing: bits streamed LSB-first, words cut every RW bits
    task automatic model_accept(input logic [PW-1:0] pix, input logic s);
        if (s) begin
            if (m_active) err_exp = 1'b1;
            bit_q.delete();
            m_adr    = 0;
            m_active = 1'b1;
        end
        if (m_active) begin
            for (int i = 0; i < PW; i++) bit_q.push_back(pix[i]);
            while (bit_q.size() >= RW) begin
                wr_t e;
                for (int i = 0; i < RW; i++) e.data[i] = bit_q.pop_front();
                e.adr = m_adr;
                sb_q.push_back(e);
                if (m_adr == MAXA) begin
                    m_adr    = 0;
                    m_active = 1'b0;
                    bit_q.delete();
                end else begin
                    m_adr++;
                end
            end
        end
    endtask

    task automatic send_pixel(input logic [PW-1:0] pix, input logic s);
        bit done = 1'b0;
        pixel       = pix;
        sof         = s;
        pixel_valid = 1'b1;
        for (int t = 0; t < 200 && !done; t++) begin
            if (throttle) ram_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (pixel_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        pixel_valid = 1'b0;
        sof         = 1'b0;
        if (done) model_accept(pix, s);
        else check_value("accept_timeout", 64'(done), 64'(1));
    endtask

    task automatic drain();
        throttle  = 1'b0;
        ram_ready = 1'b1;
        for (int t = 0; t < 50 && sb_q.size() != 0; t++) begin
            @(posedge clk);
            #1;
        end
        repeat (3) @(posedge clk);
        #1;
        check_value("drain_empty", 64'(sb_q.size()), 64'(0));
    endtask

    task automatic end_frame_checks(input int exp_writes, input int exp_done);
        check_value("frame_writes", 64'(write_cnt), 64'(exp_writes));
        check_value("frame_done_cnt", 64'(done_cnt), 64'(exp_done));
        check_value("end_adress", 64'(adress), 64'(0));
        check_value("end_we", 64'(we), 64'(0));
        check_value("end_state", 64'(dut.r_state), 64'(ST_IDLE));
    endtask

    // Write-port monitor: pops the scoreboard on each retiring write
    always @(negedge clk) begin
        wr_t e;
        check_value("frame_done", 64'(frame_done), 64'(done_exp));
        check_value("frame_err", 64'(frame_err), 64'(err_exp));
        if (frame_done) done_cnt++;
        if (frame_err) err_cnt++;
        err_exp  = 1'b0;
        done_exp = 1'b0;
        if (rst && we && ram_ready) begin
            write_cnt++;
            if (sb_q.size() == 0) begin
                check_value("unexpected_write", 64'(sb_q.size()), 64'(1));
            end else begin
                e = sb_q.pop_front();
                check_value("wr_adress", 64'(adress), 64'(e.adr));
                check_value("wr_data", 64'(data_out), 64'(e.data));
                done_exp = (e.adr == MAXA);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit            bp_done = 1'b0;
        logic [PW-1:0] p_new;
        int            n;

        repeat (3) @(posedge clk);
        #1;
        check_value("rst_we", 64'(we), 64'(0));
        check_value("rst_adress", 64'(adress), 64'(0));
        check_value("rst_data", 64'(data_out), 64'(0));
        check_value("rst_done", 64'(frame_done), 64'(0));
        check_value("rst_err", 64'(frame_err), 64'(0));
        check_value("rst_state", 64'(dut.r_state), 64'(ST_IDLE));
        #2 rst = 1'b1;
        @(posedge clk);
        #1;

        // Frame 1: known packing, then random fill with one backpressure stall
        write_cnt = 0;
        send_pixel(24'hAABBCC, 1'b1);
        check_value("p0_we", 64'(we), 64'(0));
        send_pixel(24'h112233, 1'b0);
        check_value("w0_we", 64'(we), 64'(1));
        check_value("w0_adr", 64'(adress), 64'(0));
        check_value("w0_data", 64'(data_out), 64'(32'h33AABBCC));
        send_pixel(24'h445566, 1'b0);
        check_value("w1_adr", 64'(adress), 64'(1));
        check_value("w1_data", 64'(data_out), 64'(32'h55661122));
        send_pixel(24'h778899, 1'b0);
        check_value("w2_adr", 64'(adress), 64'(2));
        check_value("w2_data", 64'(data_out), 64'(32'h77889944));
        for (int i = 4; i < PIX_PER_FRAME; i++) begin
            send_pixel(PW'($urandom), 1'b0);
            if (i >= 20 && !bp_done && we) begin
                bp_done     = 1'b1;
                ram_ready   = 1'b0;
                pixel       = PW'($urandom);
                pixel_valid = 1'b1;
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    check_value("bp_we", 64'(we), 64'(1));
                    check_value("bp_adr", 64'(adress), 64'(sb_q[0].adr));
                    check_value("bp_data", 64'(data_out), 64'(sb_q[0].data));
                    check_value("bp_ready", 64'(pixel_ready), 64'(0));
                end
                @(posedge clk);
                #1;
                pixel_valid = 1'b0;
                ram_ready   = 1'b1;
            end
        end
        check_value("bp_seen", 64'(bp_done), 64'(1));
        drain();
        end_frame_checks(DEPTH, 1);

        // Idle: pixels without sof are swallowed
        write_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            p_new       = PW'($urandom);
            pixel       = p_new;
            sof         = 1'b0;
            pixel_valid = 1'b1;
            @(negedge clk);
            check_value("idle_ready", 64'(pixel_ready), 64'(1));
            @(posedge clk);
            #1;
            model_accept(p_new, 1'b0);
        end
        pixel_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_value("idle_writes", 64'(write_cnt), 64'(0));
        check_value("idle_we", 64'(we), 64'(0));

        // New frame, then sof again at pixel 10
        send_pixel(PW'($urandom), 1'b1);
        check_value("start_adr", 64'(adress), 64'(0));
        for (int i = 1; i < 10; i++) send_pixel(PW'($urandom), 1'b0);
        p_new = PW'($urandom);
        send_pixel(p_new, 1'b1);
        send_pixel(PW'($urandom), 1'b0);
        check_value("restart_we", 64'(we), 64'(1));
        check_value("restart_adr", 64'(adress), 64'(0));
        check_value("restart_pix", 64'(data_out[PW-1:0]), 64'(p_new));
        check_value("err_cnt", 64'(err_cnt), 64'(1));

        // Asynchronous reset while a write is pending
        n = 0;
        do begin
            send_pixel(PW'($urandom), 1'b0);
            n++;
        end while ((n < 3 || !we) && n < 10);
        check_value("pre_rst_we", 64'(we), 64'(1));
        #2 rst = 1'b0;
        sb_q.delete();
        bit_q.delete();
        m_active = 1'b0;
        m_adr    = 0;
        #1;
        check_value("arst_we", 64'(we), 64'(0));
        check_value("arst_adr", 64'(adress), 64'(0));
        check_value("arst_data", 64'(data_out), 64'(0));
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;

        // Full frame under random ram_ready throttling
        write_cnt = 0;
        throttle  = 1'b1;
        send_pixel(PW'($urandom), 1'b1);
        for (int i = 1; i < PIX_PER_FRAME; i++) send_pixel(PW'($urandom), 1'b0);
        drain();
        end_frame_checks(DEPTH, 2);
        check_value("err_cnt_end", 64'(err_cnt), 64'(1));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
